// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory slave between the instruction and data masters.
// Completed responses stay sticky until the pipeline advances; a watchdog aborts hung slaves.
module bus_arbiter #(
  parameter int unsigned         P_ADDR_W   = 32,
  parameter int unsigned         P_DATA_W   = 32,
  parameter int unsigned         P_TIMEOUT  = 255,
  parameter logic [P_DATA_W-1:0] P_ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                advance,
  input  logic                ins_valid,
  input  logic [P_ADDR_W-1:0] ins_addr,
  input  logic                ins_wr,
  input  logic [P_DATA_W-1:0] ins_wdata,
  output logic                ins_ready,
  output logic [P_DATA_W-1:0] ins_rdata,
  input  logic                data_valid,
  input  logic [P_ADDR_W-1:0] data_addr,
  input  logic                data_wr,
  input  logic [P_DATA_W-1:0] data_wdata,
  output logic                data_ready,
  output logic [P_DATA_W-1:0] data_rdata,
  output logic                mem_valid,
  output logic [P_ADDR_W-1:0] mem_addr,
  output logic                mem_wr,
  output logic [P_DATA_W-1:0] mem_wdata,
  input  logic                mem_ready,
  input  logic [P_DATA_W-1:0] mem_rdata,
  output logic                timeout_err
);

  localparam int unsigned     CntW    = $clog2(P_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(P_TIMEOUT - 1);
  localparam logic            GrantIns  = 1'b0;
  localparam logic            GrantData = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_INS, S_DATA} arbState;

  arbState             stateQ, stateD;
  logic                lastGrantQ, lastGrantD;
  logic                insDoneQ, insDoneD;
  logic                dataDoneQ, dataDoneD;
  logic [P_DATA_W-1:0] insRdataQ, insRdataD;
  logic [P_DATA_W-1:0] dataRdataQ, dataRdataD;
  logic [P_ADDR_W-1:0] memAddrQ, memAddrD;
  logic                memWrQ, memWrD;
  logic [P_DATA_W-1:0] memWdataQ, memWdataD;
  logic [CntW-1:0]     cntQ, cntD;
  logic                timeoutErrQ, timeoutErrD;
  logic                insPend, dataPend, pickData;
  logic [P_DATA_W-1:0] respData;

  always_comb begin
    // Pending uses the registered done flags, so an advance in this cycle cannot re-grant.
    insPend  = ins_valid & ~insDoneQ;
    dataPend = data_valid & ~dataDoneQ;
    pickData = dataPend & (~insPend | (lastGrantQ == GrantIns));
    respData = mem_ready ? mem_rdata : P_ERR_DATA;

    stateD      = stateQ;
    lastGrantD  = lastGrantQ;
    insDoneD    = insDoneQ & ~advance;
    dataDoneD   = dataDoneQ & ~advance;
    insRdataD   = insRdataQ;
    dataRdataD  = dataRdataQ;
    memAddrD    = memAddrQ;
    memWrD      = memWrQ;
    memWdataD   = memWdataQ;
    cntD        = cntQ;
    timeoutErrD = timeoutErrQ;

    case (stateQ)
      S_IDLE: begin
        if (pickData) begin
          stateD     = S_DATA;
          lastGrantD = GrantData;
          memAddrD   = data_addr;
          memWrD     = data_wr;
          memWdataD  = data_wdata;
          cntD       = '0;
        end else if (insPend) begin
          stateD     = S_INS;
          lastGrantD = GrantIns;
          memAddrD   = ins_addr;
          memWrD     = ins_wr;
          memWdataD  = ins_wdata;
          cntD       = '0;
        end
      end
      S_INS, S_DATA: begin
        if (mem_ready || (cntQ == CntLast)) begin
          stateD = S_IDLE;
          if (stateQ == S_DATA) begin
            dataDoneD  = 1'b1;
            dataRdataD = respData;
          end else begin
            insDoneD  = 1'b1;
            insRdataD = respData;
          end
          if (!mem_ready) timeoutErrD = 1'b1;
        end else begin
          cntD = cntQ + CntW'(1);
        end
      end
      default: stateD = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ      <= S_IDLE;
      lastGrantQ  <= GrantIns;
      insDoneQ    <= 1'b0;
      dataDoneQ   <= 1'b0;
      insRdataQ   <= '0;
      dataRdataQ  <= '0;
      memAddrQ    <= '0;
      memWrQ      <= 1'b0;
      memWdataQ   <= '0;
      cntQ        <= '0;
      timeoutErrQ <= 1'b0;
    end else begin
      stateQ      <= stateD;
      lastGrantQ  <= lastGrantD;
      insDoneQ    <= insDoneD;
      dataDoneQ   <= dataDoneD;
      insRdataQ   <= insRdataD;
      dataRdataQ  <= dataRdataD;
      memAddrQ    <= memAddrD;
      memWrQ      <= memWrD;
      memWdataQ   <= memWdataD;
      cntQ        <= cntD;
      timeoutErrQ <= timeoutErrD;
    end
  end

  assign ins_ready   = insDoneQ;
  assign ins_rdata   = insRdataQ;
  assign data_ready  = dataDoneQ;
  assign data_rdata  = dataRdataQ;
  assign mem_valid   = (stateQ != S_IDLE);
  assign mem_addr    = memAddrQ;
  assign mem_wr      = memWrQ;
  assign mem_wdata   = memWdataQ;
  assign timeout_err = timeoutErrQ;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a slave model answers requests and a grant scoreboard
// checks the order and fields of every slave transaction; a second instance covers timeout.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        advance = 1'b0;
  logic        ins_valid = 1'b0, ins_wr = 1'b0;
  logic [31:0] ins_addr = '0, ins_wdata = '0;
  logic        data_valid = 1'b0, data_wr = 1'b0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        ins_ready, data_ready, mem_valid, mem_wr, timeout_err;
  logic [31:0] ins_rdata, data_rdata, mem_addr, mem_wdata;
  logic        memReady = 1'b0;
  logic [31:0] memRdata = '0;

  logic        t2InsReady, t2DataReady, t2MemValid, t2MemWr, t2TimeoutErr;
  logic [31:0] t2InsRdata, t2DataRdata, t2MemAddr, t2MemWdata;
  logic        zeroBit = 1'b0;
  logic [31:0] zeroWord = '0;

  int nAsserts = 0;
  int nFails   = 0;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grantT;
  grantT grantQ[$];

  bit          slaveOn   = 1'b1;
  logic [31:0] stallAddr = 32'hFFFF_FFF0;

  always #5 clk = ~clk;

  bus_arbiter #(.P_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .advance(advance),
    .ins_valid(ins_valid), .ins_addr(ins_addr), .ins_wr(ins_wr), .ins_wdata(ins_wdata),
    .ins_ready(ins_ready), .ins_rdata(ins_rdata),
    .data_valid(data_valid), .data_addr(data_addr), .data_wr(data_wr),
    .data_wdata(data_wdata), .data_ready(data_ready), .data_rdata(data_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_ready(memReady), .mem_rdata(memRdata), .timeout_err(timeout_err)
  );

  // Slave never answers this instance, so every grant runs into the watchdog.
  bus_arbiter #(.P_TIMEOUT(4)) dutTo (
    .clk(clk), .rst(rst), .advance(advance),
    .ins_valid(ins_valid), .ins_addr(ins_addr), .ins_wr(ins_wr), .ins_wdata(ins_wdata),
    .ins_ready(t2InsReady), .ins_rdata(t2InsRdata),
    .data_valid(data_valid), .data_addr(data_addr), .data_wr(data_wr),
    .data_wdata(data_wdata), .data_ready(t2DataReady), .data_rdata(t2DataRdata),
    .mem_valid(t2MemValid), .mem_addr(t2MemAddr), .mem_wr(t2MemWr), .mem_wdata(t2MemWdata),
    .mem_ready(zeroBit), .mem_rdata(zeroWord), .timeout_err(t2TimeoutErr)
  );

  function automatic logic [31:0] slaveData(input logic [31:0] a);
    if (a == 32'h100) return 32'h13;
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectGrant(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    grantT g;
    g.wr    = wr;
    g.addr  = a;
    g.wdata = wd;
    grantQ.push_back(g);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic waitReady(input bit needIns, input bit needData, input int maxCyc);
    int n = 0;
    while (!((!needIns || ins_ready) && (!needData || data_ready)) && n < maxCyc) begin
      tick();
      n++;
    end
    chkBit("wait_ready_in_budget", n < maxCyc, 1'b1);
  endtask

  task automatic releaseAll();
    advance    = 1'b1;
    ins_valid  = 1'b0;
    data_valid = 1'b0;
    tick();
    advance = 1'b0;
    tick();
    chkBit("ready_cleared_ins", ins_ready, 1'b0);
    chkBit("ready_cleared_data", data_ready, 1'b0);
  endtask

  // Slave model and grant scoreboard for the main instance.
  initial begin
    int  waitCnt = 0;
    int  lat;
    bit  prevValid = 1'b0;
    grantT g;
    forever begin
      tick();
      if (memReady) begin
        memReady = 1'b0;
      end else if (mem_valid) begin
        if (!prevValid) begin
          chkBit("grant_expected", grantQ.size() != 0, 1'b1);
          if (grantQ.size() != 0) begin
            g = grantQ.pop_front();
            chkWord("grant_addr", mem_addr, g.addr);
            chkBit("grant_wr", mem_wr, g.wr);
            chkWord("grant_wdata", mem_wdata, g.wdata);
          end
        end
        lat = (mem_addr == stallAddr) ? 10 : 1;
        if (slaveOn && waitCnt == lat) begin
          memReady = 1'b1;
          memRdata = slaveData(mem_addr);
          waitCnt  = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
      prevValid = mem_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;

    // Reset state
    tick();
    tick();
    chkBit("rst_ins_ready", ins_ready, 1'b0);
    chkBit("rst_data_ready", data_ready, 1'b0);
    chkBit("rst_mem_valid", mem_valid, 1'b0);
    chkBit("rst_mem_wr", mem_wr, 1'b0);
    chkBit("rst_timeout_err", timeout_err, 1'b0);
    chkWord("rst_ins_rdata", ins_rdata, 32'h0);
    chkWord("rst_data_rdata", data_rdata, 32'h0);
    chkWord("rst_mem_addr", mem_addr, 32'h0);
    chkWord("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // Single fetch
    ins_valid = 1'b1;
    ins_addr  = 32'h100;
    expectGrant(1'b0, 32'h100, 32'h0);
    tick();
    chkBit("fetch_mem_valid_t1", mem_valid, 1'b1);
    chkWord("fetch_mem_addr_t1", mem_addr, 32'h100);
    tick();
    chkBit("fetch_ins_ready_t2", ins_ready, 1'b0);
    tick();
    chkBit("fetch_ins_ready_t3", ins_ready, 1'b1);
    chkWord("fetch_ins_rdata_t3", ins_rdata, 32'h13);
    chkBit("fetch_mem_valid_t3", mem_valid, 1'b0);
    tick();
    tick();
    chkBit("fetch_ins_ready_held", ins_ready, 1'b1);
    chkWord("fetch_ins_rdata_held", ins_rdata, 32'h13);
    // valid still high during advance: done master must not be re-granted that cycle
    advance = 1'b1;
    tick();
    advance   = 1'b0;
    ins_valid = 1'b0;
    chkBit("fetch_ins_ready_after_adv", ins_ready, 1'b0);
    chkBit("fetch_no_regrant_on_adv", mem_valid, 1'b0);
    tick();
    chkBit("fetch_idle_after_drop", mem_valid, 1'b0);

    // Simultaneous after reset: data first, one idle bubble, then ins
    doReset();
    ins_valid  = 1'b1;
    ins_addr   = 32'h200;
    data_valid = 1'b1;
    data_addr  = 32'h40;
    data_wr    = 1'b1;
    data_wdata = 32'hAA;
    expectGrant(1'b1, 32'h40, 32'hAA);
    expectGrant(1'b0, 32'h200, 32'h0);
    tick();
    tick();
    tick();
    chkBit("simul_bubble_idle", mem_valid, 1'b0);
    chkBit("simul_data_ready_first", data_ready, 1'b1);
    chkBit("simul_ins_not_ready_yet", ins_ready, 1'b0);
    tick();
    chkBit("simul_ins_granted", mem_valid, 1'b1);
    tick();
    tick();
    chkBit("simul_both_ready_ins", ins_ready, 1'b1);
    chkBit("simul_both_ready_data", data_ready, 1'b1);
    chkWord("simul_ins_rdata", ins_rdata, slaveData(32'h200));
    chkWord("simul_data_rdata", data_rdata, slaveData(32'h40));
    releaseAll();

    // Round robin across four transactions
    data_wr    = 1'b0;
    data_wdata = 32'h1234;
    ins_valid  = 1'b1;
    ins_addr   = 32'h300;
    data_valid = 1'b1;
    data_addr  = 32'h80;
    expectGrant(1'b0, 32'h80, 32'h1234);
    expectGrant(1'b0, 32'h300, 32'h0);
    waitReady(1'b1, 1'b1, 20);
    chkWord("rr1_ins_rdata", ins_rdata, slaveData(32'h300));
    chkWord("rr1_data_rdata", data_rdata, slaveData(32'h80));
    advance   = 1'b1;
    ins_addr  = 32'h304;
    data_addr = 32'h84;
    expectGrant(1'b0, 32'h84, 32'h1234);
    expectGrant(1'b0, 32'h304, 32'h0);
    tick();
    advance = 1'b0;
    waitReady(1'b1, 1'b1, 20);
    chkWord("rr2_ins_rdata", ins_rdata, slaveData(32'h304));
    chkWord("rr2_data_rdata", data_rdata, slaveData(32'h84));
    releaseAll();

    // Sticky hold: data done while ins stalls in the slave
    stallAddr  = 32'h400;
    ins_valid  = 1'b1;
    ins_addr   = 32'h400;
    data_valid = 1'b1;
    data_addr  = 32'h90;
    expectGrant(1'b0, 32'h90, 32'h1234);
    expectGrant(1'b0, 32'h400, 32'h0);
    waitReady(1'b0, 1'b1, 10);
    held = 0;
    while (!ins_ready && held < 25) begin
      chkBit("hold_data_ready", data_ready, 1'b1);
      chkWord("hold_data_rdata", data_rdata, slaveData(32'h90));
      tick();
      held++;
    end
    chkBit("hold_stall_length", held >= 10 && held < 25, 1'b1);
    chkWord("hold_ins_rdata", ins_rdata, slaveData(32'h400));
    chkBit("hold_data_still_ready", data_ready, 1'b1);
    releaseAll();
    stallAddr = 32'hFFFF_FFF0;

    // Timeout on the P_TIMEOUT=4 instance
    doReset();
    slaveOn   = 1'b0;
    ins_valid = 1'b1;
    ins_addr  = 32'h500;
    expectGrant(1'b0, 32'h500, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chkBit("to_mem_valid", t2MemValid, 1'b1);
      chkBit("to_ins_not_ready", t2InsReady, 1'b0);
      chkBit("to_err_not_yet", t2TimeoutErr, 1'b0);
    end
    chkWord("to_mem_addr", t2MemAddr, 32'h500);
    tick();
    chkBit("to_aborted", t2MemValid, 1'b0);
    chkBit("to_ins_ready", t2InsReady, 1'b1);
    chkWord("to_ins_rdata", t2InsRdata, 32'hDEAD_BEEF);
    chkBit("to_err_set", t2TimeoutErr, 1'b1);
    advance   = 1'b1;
    ins_valid = 1'b0;
    tick();
    advance = 1'b0;
    tick();
    tick();
    chkBit("to_ins_cleared", t2InsReady, 1'b0);
    chkBit("to_err_sticky", t2TimeoutErr, 1'b1);
    doReset();
    chkBit("to_err_cleared_by_rst", t2TimeoutErr, 1'b0);
    chkBit("to_main_idle_after_rst", mem_valid, 1'b0);
    slaveOn = 1'b1;

    // Reset mid-transaction, then data wins the first simultaneous grant
    stallAddr  = 32'h600;
    data_valid = 1'b1;
    data_addr  = 32'h600;
    data_wr    = 1'b1;
    data_wdata = 32'h55;
    expectGrant(1'b1, 32'h600, 32'h55);
    tick();
    chkBit("midrst_in_data", mem_valid, 1'b1);
    tick();
    rst        = 1'b1;
    data_valid = 1'b0;
    tick();
    chkBit("midrst_mem_valid", mem_valid, 1'b0);
    chkBit("midrst_ins_ready", ins_ready, 1'b0);
    chkBit("midrst_data_ready", data_ready, 1'b0);
    tick();
    rst        = 1'b0;
    data_wr    = 1'b0;
    data_wdata = 32'h0;
    ins_valid  = 1'b1;
    ins_addr   = 32'h700;
    data_valid = 1'b1;
    data_addr  = 32'h680;
    expectGrant(1'b0, 32'h680, 32'h0);
    expectGrant(1'b0, 32'h700, 32'h0);
    waitReady(1'b1, 1'b1, 20);
    chkWord("post_rst_ins_rdata", ins_rdata, slaveData(32'h700));
    chkWord("post_rst_data_rdata", data_rdata, slaveData(32'h680));
    releaseAll();
    tick();
    chkWord("grant_queue_drained", grantQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one memory slave port between the CPU instruction-fetch master and the data (load/store) master.
- Sits between the CPU core's two bus master ports and the single memory/cache backend.
- Performs round-robin arbitration and holds completed responses until the CPU pipeline advances. This is needed because the core only advances when both of its ports are ready in the same cycle.
- Includes a watchdog timeout that aborts a hung slave transaction.

Parameters:
- P_ADDR_W, 32: address width.
- P_DATA_W, 32: data width.
- P_TIMEOUT, 255: maximum cycles `mem_valid` may stay high without `mem_ready` before the transaction is aborted. Must be ≥1.
- P_ERR_DATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- advance  in  1  pulse: the CPU pipeline advances this cycle (all active ports ready)
- ins_valid  in  1  instruction master request
- ins_addr  in  P_ADDR_W  instruction address
- ins_wr  in  1  instruction write (normally 0)
- ins_wdata  in  P_DATA_W  instruction write data
- ins_ready  out  1  instruction response available (sticky)
- ins_rdata  out  P_DATA_W  instruction read data
- data_valid  in  1  data master request
- data_addr  in  P_ADDR_W  data address
- data_wr  in  1  1 = store
- data_wdata  in  P_DATA_W  store data
- data_ready  out  1  data response available (sticky)
- data_rdata  out  P_DATA_W  load data
- mem_valid  out  1  slave request
- mem_addr  out  P_ADDR_W  slave address
- mem_wr  out  1  slave write
- mem_wdata  out  P_DATA_W  slave write data
- mem_ready  in  1  slave completion, single-cycle pulse
- mem_rdata  in  P_DATA_W  slave read data, valid with `mem_ready`
- timeout_err  out  1  sticky: a timeout occurred

Behaviour:
- Reset values:
  - state = S_IDLE; `last_grant` = INS; all done flags = 0.
  - Outputs `ins_ready`, `data_ready`, `mem_valid`, `mem_wr`, `timeout_err` = 0.
  - Outputs `ins_rdata`, `data_rdata`, `mem_addr`, `mem_wdata` = 0.
  - Timeout counter = 0.
- Per-master pending = `valid` & !done, using registered done.
- State machine has three states: S_IDLE, S_INS, S_DATA.
- S_IDLE:
  - Only ins pending → S_INS. Only data pending → S_DATA.
  - Both pending → grant the master ≠ `last_grant`. After reset, data wins first.
  - On grant: capture the master's addr/wr/wdata into the `mem_*` registers, set `last_grant`, clear the timeout counter.
  - None pending → stay in S_IDLE.
- S_INS / S_DATA:
  - `mem_valid` = 1; `mem_*` request fields held stable (registered).
  - On `mem_ready`: `mem_rdata` is latched into the granted master's rdata register, its done flag is set, and the state returns to S_IDLE. `mem_valid` drops the next cycle.
  - Without `mem_ready`: the counter increments. When it reaches P_TIMEOUT:
    - the transaction is aborted;
    - the granted master's rdata is set to P_ERR_DATA and its done flag is set;
    - `timeout_err` is set to 1;
    - the state returns to S_IDLE.
    - `mem_ready` in that same cycle takes precedence; no error.
- Latency:
  - Request seen in S_IDLE at cycle t → `mem_valid` at t+1.
  - `mem_ready` at cycle u → master ready at u+1.
  - Minimum request-to-ready is 2 cycles plus slave latency. There is one idle bubble between back-to-back grants.
- Master ready outputs:
  - `x_ready` = done_x; `x_rdata` is held while done.
  - `advance` clears both done flags at the clock edge.
  - A master is never re-requested while done = 1, even if its `valid` stays high.
  - A master with `valid` = 0 is never granted; its ready stays 0.
- Simultaneous events:
  - `advance` and a grant in the same cycle: the grant uses pre-clear pending, so a done master is not re-granted that cycle.
  - `valid` is sampled only in S_IDLE. Deassertion during grant does not abort the slave transaction; the result is still latched as done.
- Reset mid-transaction: immediate return to S_IDLE and `mem_valid` = 0 the next cycle. The slave must tolerate the abandoned request.
- `timeout_err` is cleared only by `rst`.

Test Plan:
- Single fetch:
  - Stimulus: `ins_valid`=1, `ins_addr`=0x100. Slave returns 0x13 with `mem_ready` one cycle after `mem_valid`.
  - Required: `mem_valid`@t+1 with `mem_addr`=0x100, `mem_wr`=0; `ins_ready`=1 with `ins_rdata`=0x13 @t+3; held until `advance`, then 0.
- Simultaneous after reset:
  - Stimulus: ins @0x200 and data store @0x40 with wdata 0xAA.
  - Required: data is served first (`mem_wr`=1, `mem_wdata`=0xAA), one S_IDLE cycle, then ins. Both readies are high together before `advance`.
- Round-robin:
  - Stimulus: both masters continuously valid, `advance` pulsed after both are ready.
  - Required: grant order data, ins, data, ins… across four transactions.
- Sticky hold:
  - Stimulus: data done while ins is stalled 10 cycles in the slave.
  - Required: `data_ready` and `data_rdata` stay constant for all 10 cycles; no second data grant occurs before `advance`.
- Timeout:
  - Stimulus: P_TIMEOUT=4, `mem_ready` never asserted.
  - Required: abort after 4 cycles of `mem_valid`; `ins_rdata`=0xDEADBEEF; `ins_ready`=1; `timeout_err`=1 until `rst`.
- Reset mid-operation:
  - Stimulus: `rst` asserted while in S_DATA.
  - Required: next cycle `mem_valid`=0, readies=0, S_IDLE. Afterwards, simultaneous requests grant data first.
